// File: rtl/bp_stream_byte_packer_pkg.sv
// Shared types and constants for the host byte link -> NBF stream packer.
package bp_stream_byte_packer_pkg;

    localparam int bp_stream_data_width_gp = 32;
    localparam int bp_byte_width_gp        = 8;
    localparam int bp_timeout_cycles_gp    = 1024;

    function automatic int bytes_per_word(input int word_width, input int byte_width);
        return word_width / byte_width;
    endfunction

    // Shared with the loader so its flit count agrees with the packer
    localparam int bp_bytes_per_word_gp = bytes_per_word(bp_stream_data_width_gp, bp_byte_width_gp);

    typedef logic [bp_stream_data_width_gp-1:0] bp_stream_word_t;

endpackage

// File: rtl/bp_stream_byte_packer_out_reg.sv
// One-word valid/ready output register; a new word may load in the same cycle
// the held word drains, so back-to-back words leave no bubble.
module bp_stream_packer_out_reg #(
    parameter int width_p = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [width_p-1:0] load_data,
    input  logic               ready,
    output logic               valid,
    output logic [width_p-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid & ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bp_stream_byte_packer.sv
// Packs host link bytes little-endian into stream words for the NBF loader.
// Optional partial-word idle timeout: define BP_STREAM_PACKER_TIMEOUT_EN.
module bp_stream_byte_packer
    import bp_stream_byte_packer_pkg::*;
#(
    parameter int stream_data_width_p = bp_stream_data_width_gp,
    parameter int byte_width_p        = bp_byte_width_gp,
    parameter int timeout_cycles_p    = bp_timeout_cycles_gp
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           byte_v_i,
    input  logic [byte_width_p-1:0]        byte_i,
    output logic                           byte_ready_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
    output logic [31:0]                    word_count_o,
    output logic                           error_o
);

    localparam int bytes_per_word_lp = bytes_per_word(stream_data_width_p, byte_width_p);
    localparam int idx_w_lp = (bytes_per_word_lp > 1) ? $clog2(bytes_per_word_lp) : 1;
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(bytes_per_word_lp - 1);

    logic [idx_w_lp-1:0]            idx_r;
    logic [stream_data_width_p-1:0] asm_r, asm_next;
    logic [31:0]                    word_count_r;
    logic                           last, accept, complete, xfer, drop;

    assign last         = (idx_r == last_idx_lp);
    // Only the final byte of a word is refused while the output is stalled
    assign byte_ready_o = ~(stream_v_o & ~stream_ready_i & last);
    assign accept       = byte_v_i & byte_ready_o;
    assign complete     = accept & last;
    assign xfer         = stream_v_o & stream_ready_i;

    always_comb begin
        asm_next = asm_r;
        asm_next[idx_r*byte_width_p +: byte_width_p] = byte_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_r <= '0;
            asm_r <= '0;
        end else if (accept) begin
            if (complete) begin
                idx_r <= '0;
                asm_r <= '0;
            end else begin
                idx_r <= idx_r + 1'b1;
                asm_r <= asm_next;
            end
        end else if (drop) begin
            idx_r <= '0;
            asm_r <= '0;
        end
    end

    bp_stream_packer_out_reg #(
        .width_p(stream_data_width_p)
    ) out_reg (
        .clk      (clk_i),
        .reset    (reset_i),
        .load     (complete),
        .load_data(asm_next),
        .ready    (stream_ready_i),
        .valid    (stream_v_o),
        .data     (stream_data_o)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) word_count_r <= '0;
        else if (xfer) word_count_r <= word_count_r + 32'd1;
    end

    assign word_count_o = word_count_r;

`ifdef BP_STREAM_PACKER_TIMEOUT_EN
    localparam int tmr_w_lp = $clog2(timeout_cycles_p + 1);

    logic [tmr_w_lp-1:0] tmr_r;
    logic                error_r;

    // Fires on the idle cycle that brings the count to timeout_cycles_p;
    // an accepted byte in that cycle suppresses it.
    assign drop = ~accept & (idx_r != '0) & (tmr_r == tmr_w_lp'(timeout_cycles_p - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tmr_r   <= '0;
            error_r <= 1'b0;
        end else if (accept || idx_r == '0) begin
            tmr_r <= '0;
        end else if (drop) begin
            tmr_r   <= '0;
            error_r <= 1'b1;
        end else begin
            tmr_r <= tmr_r + 1'b1;
        end
    end

    assign error_o = error_r;
`else
    assign drop    = 1'b0;
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_stream_byte_packer.sv
// Randomized + directed bench for bp_stream_byte_packer against a queue-based model.
module tb_bp_stream_byte_packer;
    import bp_stream_byte_packer_pkg::*;

    localparam int W   = 32;
    localparam int B   = 8;
    localparam int T   = 16;
    localparam int BPW = W / B;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          byte_v_i = 1'b0;
    logic [B-1:0]  byte_i = '0;
    logic          byte_ready_o;
    logic          stream_v_o;
    logic [W-1:0]  stream_data_o;
    logic          stream_ready_i = 1'b0;
    logic [31:0]   word_count_o;
    logic          error_o;

    bp_stream_byte_packer #(
        .stream_data_width_p(W),
        .byte_width_p       (B),
        .timeout_cycles_p   (T)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .byte_v_i      (byte_v_i),
        .byte_i        (byte_i),
        .byte_ready_o  (byte_ready_o),
        .stream_v_o    (stream_v_o),
        .stream_data_o (stream_data_o),
        .stream_ready_i(stream_ready_i),
        .word_count_o  (word_count_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: bytes of the word being gathered, the word waiting at the output
    logic [B-1:0]    part_q[$];
    bit              m_v;
    bp_stream_word_t m_word;
    logic [31:0]     m_cnt;
    bit              m_err;
    int              m_idle;

    task automatic model_reset();
        part_q.delete();
        m_v = 0; m_word = '0; m_cnt = '0; m_err = 0; m_idle = 0;
    endtask

    // Called just after a falling edge: drive, check, predict, advance one cycle
    task automatic cycle(input bit bv, input logic [B-1:0] b, input bit sr);
        bit exp_rdy, acc, was_empty;
        byte_v_i = bv; byte_i = b; stream_ready_i = sr;
        #1;
        exp_rdy = !(m_v && !sr && part_q.size() == BPW - 1);
        chk("valid", stream_v_o, m_v);
        if (m_v) chk("data", stream_data_o, m_word);
        chk("byte_ready", byte_ready_o, exp_rdy);
        chk("word_count", word_count_o, m_cnt);
        chk("error", error_o, m_err);
        acc = bv && exp_rdy;
        was_empty = (part_q.size() == 0);
        if (m_v && sr) begin m_cnt++; m_v = 0; end
`ifdef BP_STREAM_PACKER_TIMEOUT_EN
        if (acc || was_empty) m_idle = 0;
        else if (m_idle == T - 1) begin part_q.delete(); m_err = 1; m_idle = 0; end
        else m_idle++;
`endif
        if (acc) begin
            part_q.push_back(b);
            if (part_q.size() == BPW) begin
                m_word = '0;
                for (int i = 0; i < BPW; i++)
                    m_word = m_word | (bp_stream_word_t'(part_q[i]) << (B * i));
                m_v = 1;
                part_q.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        byte_v_i = 0;
        #2 reset_i = 1'b1;
        #1;
        chk("rst_valid", stream_v_o, 0);
        chk("rst_count", word_count_o, 0);
        chk("rst_error", error_o, 0);
        model_reset();
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        #1 chk("rst_ready", byte_ready_o, 1);
        @(negedge clk);

        // single word
        cycle(1, 8'h11, 1); cycle(1, 8'h22, 1); cycle(1, 8'h33, 1); cycle(1, 8'h44, 1);
        chk("w1_valid", stream_v_o, 1);
        chk("w1_data", stream_data_o, 32'h44332211);
        cycle(0, 0, 1);
        chk("w1_count", word_count_o, 1);

        // continuous stream
        for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 1);
        cycle(0, 0, 1);
        chk("stream_count", word_count_o, 3);

        // back-pressure: word pending, next word's last byte held
        for (int i = 0; i < 4; i++) cycle(1, 8'hA0 + 8'(i), 0);
        cycle(1, 8'h55, 0); cycle(1, 8'h66, 0); cycle(1, 8'h77, 0);
        cycle(1, 8'h88, 0);
        cycle(1, 8'h88, 0);
        cycle(1, 8'h88, 1);
        chk("bp_valid", stream_v_o, 1);
        chk("bp_data", stream_data_o, 32'h88776655);
        cycle(0, 0, 1);

        // async reset with a word pending and a partial word
        for (int i = 0; i < 4; i++) cycle(1, 8'hC0 + 8'(i), 0);
        cycle(1, 8'hE1, 0); cycle(1, 8'hE2, 0);
        do_reset();
        cycle(1, 8'hAA, 0); cycle(1, 8'hBB, 0); cycle(1, 8'hCC, 0); cycle(1, 8'hDD, 0);
        chk("post_rst_data", stream_data_o, 32'hDDCCBBAA);
        cycle(0, 0, 1);

`ifdef BP_STREAM_PACKER_TIMEOUT_EN
        cycle(1, 8'h5A, 1); cycle(1, 8'h5B, 1);
        for (int i = 0; i < T; i++) cycle(0, 0, 1);
        chk("tmo_error", error_o, 1);
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 1);
        chk("tmo_data", stream_data_o, 32'h04030201);
        cycle(0, 0, 1);

        do_reset();
        cycle(1, 8'h5A, 1); cycle(1, 8'h5B, 1);
        for (int i = 0; i < T - 1; i++) cycle(0, 0, 1);
        cycle(1, 8'h5C, 1);
        chk("tmo_race_error", error_o, 0);
        cycle(1, 8'h5D, 1);
        chk("tmo_race_data", stream_data_o, 32'h5D5C5B5A);
        cycle(0, 0, 1);
`endif

        // word counter wrap
        cycle(0, 0, 1);
        force dut.word_count_r = 32'hFFFF_FFFF;
        #1 release dut.word_count_r;
        m_cnt = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) cycle(1, 8'h30 + 8'(i), 1);
        cycle(0, 0, 1);
        chk("wrap_count", word_count_o, 32'h0000_0001);

        // random traffic, with occasional long idle stretches
        for (int i = 0; i < 3000; i++) begin
            bit bv;
            bv = ((i / 200) % 4 == 3) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
            cycle(bv, 8'($urandom), $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
